// File: rtl/qlearn_pkg.sv
// qlearn_pkg: shared encodings, status codes, stage indices and table address map for the Q-routing stage chain
package qlearn_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_RUN, S_FINISH} state_t;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam int STG_LEARN = 0;
  localparam int STG_SINK = 1;
  localparam int STG_AGGR = 2;
  localparam int STG_NEIGH = 3;
  localparam int STG_FWD = 4;
  localparam int STG_REWARD = 5;
  localparam int STG_UPDATE = 6;
  localparam int STG_EXPLORE = 7;
  localparam int STG_SELECT = 8;
  localparam logic [15:0] QTAB_BASE = 16'h0000;
  localparam logic [15:0] COST_BASE = 16'h0100;
  localparam logic [15:0] NEIGH_BASE = 16'h0200;
  localparam logic [15:0] PKT_BASE = 16'h0300;
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: per-stage run timer that flags the last permitted RUN cycle
module stage_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
  // cleared while a stage is being started, counts every RUN cycle
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) timer <= '0;
    else if (clr) timer <= '0;
    else if (en) timer <= timer + 1'b1;
  end
  assign timeout = en && timer == TW'(TIMEOUT - 1);
endmodule

// File: rtl/qlearn_stage_sequencer.sv
// qlearn_stage_sequencer: per-packet FSM that starts each Q-routing stage in turn and owns the shared memory mux
module qlearn_stage_sequencer
  import qlearn_pkg::*;
#(
  parameter int NUM_STAGES = 9,
  parameter int SEL_WIDTH = 4,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT = 1024,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_abort,
  output logic [SEL_WIDTH-1:0]  mem_sel,
  output logic                  mem_wr_gate,
  output logic                  sub_nrst,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [1:0]            pkt_status,
  output logic [SEL_WIDTH-1:0]  end_stage,
  output logic [WORD_WIDTH-1:0] pkt_count
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  state_t state, next_state;
  logic [SEL_WIDTH-1:0] stage;
  logic [CW-1:0] clr_cnt;
  logic sub_q, done, abort_req, last, timeout;
  assign done = stage_done[stage];
  assign abort_req = stage_abort[stage];
  assign last = stage == SEL_WIDTH'(NUM_STAGES - 1);
  assign sub_nrst = sub_q;
  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock  (clock),
    .nrst   (nrst),
    .clr    (state == S_START),
    .en     (state == S_RUN),
    .timeout(timeout)
  );
  // state register
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else state <= next_state;
  end
  // next state and Moore outputs; a done in the timeout cycle still advances
  always_comb begin
    next_state = state;
    pkt_ready = state == S_IDLE;
    busy = state != S_IDLE;
    pkt_done = state == S_FINISH;
    mem_wr_gate = state == S_START || state == S_RUN;
    mem_sel = mem_wr_gate ? stage : '0;
    stage_start = state == S_START ? NUM_STAGES'(1) << stage : '0;
    case (state)
      S_IDLE:   next_state = pkt_valid ? S_CLEAR : S_IDLE;
      S_CLEAR:  next_state = clr_cnt == CW'(CLEAR_CYCLES - 1) ? S_START : S_CLEAR;
      S_START:  next_state = S_RUN;
      S_RUN:    next_state = done ? (abort_req || last ? S_FINISH : S_START) : (timeout ? S_FINISH : S_RUN);
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end
  // stage index, soft reset, clear counter and per-packet result registers
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      stage <= '0;
      clr_cnt <= '0;
      sub_q <= 1'b0;
      pkt_status <= ST_OK;
      end_stage <= '0;
      pkt_count <= '0;
    end else begin
      sub_q <= next_state != S_CLEAR;
      clr_cnt <= state == S_CLEAR ? clr_cnt + 1'b1 : '0;
      stage <= state == S_CLEAR ? '0 : (state == S_RUN && done && !abort_req && !last) ? stage + 1'b1 : stage;
      if (state == S_IDLE && pkt_valid) begin
        pkt_status <= ST_OK;
        end_stage <= '0;
      end
      if (state == S_RUN && next_state == S_FINISH) begin
        pkt_status <= done ? (abort_req ? ST_ABORT : ST_OK) : ST_TIMEOUT;
        end_stage <= stage;
        if (done && !abort_req) pkt_count <= pkt_count + 1'b1;
      end
    end
  end
endmodule

// File: doc/qlearn_stage_sequencer.md
Name: qlearn_stage_sequencer

Overview:
- Controller that runs the per-packet Q-routing stage chain (learnCosts through selectMyAction) as an explicit FSM.
- Issues one start pulse per stage, owns the shared-memory mux select, and gates memory write enable to the active stage.
- Generates the soft stage reset between packets, terminates early on stage abort requests, and applies a per-stage watchdog.

Parameters:
- NUM_STAGES, 9, number of sequenced stages; stage index i drives mux input i.
- SEL_WIDTH, 4, width of the stage index and mux select; must satisfy 2^SEL_WIDTH >= NUM_STAGES.
- CLEAR_CYCLES, 2, cycles sub_nrst is held low before stage 0.
- TIMEOUT, 1024, maximum RUN cycles per stage before timeout.
- WORD_WIDTH, 16, width of the packet counter.

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  new packet fields stable; sampled only in IDLE.
- pkt_ready  out  1  high only in IDLE.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage i.
- stage_done  in  NUM_STAGES  per-stage done; level or pulse.
- stage_abort  in  NUM_STAGES  early-termination request; honoured only together with that stage's done.
- mem_sel  out  SEL_WIDTH  memory address/data/wren mux select.
- mem_wr_gate  out  1  AND-ed with the muxed wr_en; high only in START/RUN.
- sub_nrst  out  1  active-low soft reset to all stage modules.
- busy  out  1  high whenever not IDLE.
- pkt_done  out  1  one-cycle pulse at packet end.
- pkt_status  out  2  00 complete, 01 aborted, 10 timeout; held until next accept.
- end_stage  out  SEL_WIDTH  index of the stage active at packet end.
- pkt_count  out  WORD_WIDTH  count of completed packets; wraps.

Behaviour:
- Reset (nrst low, asynchronous): state IDLE, stage=0, timer=0, all stage_start=0, mem_sel=0, mem_wr_gate=0, sub_nrst=0, busy=0, pkt_done=0, pkt_status=00, end_stage=0, pkt_count=0. sub_nrst rises to 1 on the first clock edge after nrst deasserts.
- IDLE: pkt_ready=1, sub_nrst=1. If pkt_valid is high at an edge, go to CLEAR and clear the clear-counter.
- CLEAR: sub_nrst=0 for exactly CLEAR_CYCLES cycles, then go to START with stage=0. pkt_status and end_stage reset to 0 on entry.
- START: for one cycle, stage_start[stage]=1, mem_sel=stage, mem_wr_gate=1, timer=0. Next state is RUN.
- RUN: mem_sel=stage, mem_wr_gate=1, timer increments every cycle. stage_done[stage] is sampled at each edge; done bits of other stages are ignored.
  - done with abort: go to FINISH, status=01.
  - done on stage NUM_STAGES-1: go to FINISH, status=00, pkt_count+1.
  - done otherwise: stage+1, go to START. Stage-to-stage overhead is 1 cycle.
  - timer == TIMEOUT-1 without done: go to FINISH, status=10.
  - done and timeout in the same cycle: done wins.
  - abort without done: ignored.
- FINISH: pkt_done=1 for one cycle, end_stage=stage, mem_wr_gate=0, mem_sel=0. Next state is IDLE.
- Latency: pkt_valid accepted at edge t gives stage_start[0] in cycle t+CLEAR_CYCLES+1.
- pkt_valid outside IDLE is ignored; nothing is queued.
- Stage done bits observed during START are ignored. Stale level-dones are removed by sub_nrst in CLEAR.
- Stages without memory traffic (amIForwarding) still receive a select; their wr_en is 0.
- Reset mid-packet: immediate return to IDLE. No pkt_done pulse and no count increment for the interrupted packet.

Decomposition:
- Shared package (qlearn_pkg) holds:
  - state encodings (IDLE, CLEAR, START, RUN, FINISH);
  - pkt_status codes;
  - stage index constants (STG_LEARN=0 … STG_SELECT=8);
  - the memory address-map constants for the table regions.
- One sub-module, stage_watchdog, contains the timer, its clear/enable, and the timeout flag. Everything else stays in the FSM.

Test Plan:
- All 9 stages complete: pkt_valid pulse at cycle 10; each stage returns done 3 cycles after its start.
  - Required: start pulses in cycles 13, 17, 21, …, 45; mem_sel tracks 0..8; pkt_done in cycle 49 with status 00, end_stage 8, pkt_count 1.
- Abort at stage 1 (amISink, forAggregation): done and abort on stage 1.
  - Required: FINISH with status 01, end_stage 1; stage_start[2] never pulses; pkt_count unchanged.
  - A second packet then shows sub_nrst low for 2 cycles and restarts at stage 0.
- Watchdog, TIMEOUT=16: stage 4 never asserts done.
  - Required: status 10 exactly 16 cycles after stage_start[4].
  - Variant with done in the same cycle as timeout: status is not timeout, and stage_start[5] pulses.
- Spurious inputs: stage_done[6] high while stage 2 is running, and pkt_valid pulsed while busy.
  - Required: no advance beyond stage 2, no second packet started, pkt_ready stays 0.
- Reset mid-operation: nrst low for 7 ns during RUN of stage 3.
  - Required: asynchronously all outputs return to reset values, with no pkt_done and pkt_count unchanged.
  - A subsequent packet completes normally.
- pkt_count wrap (WORD_WIDTH=4): 16 completed packets.
  - Required: pkt_count goes 15 → 0; mem_wr_gate is 0 in every IDLE, CLEAR and FINISH cycle.
